// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per clock, start/busy/done handshake.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       DivOp,
  input  logic [WIDTH-1:0] RUrs1,
  input  logic [WIDTH-1:0] RUrs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DivRes
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rem_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;

  // Operand decode, only meaningful in the cycle a start is accepted.
  logic             op_signed;
  logic             op_rem;
  logic             rs1_neg;
  logic             rs2_neg;
  logic [WIDTH-1:0] rs1_mag;
  logic [WIDTH-1:0] rs2_mag;
  logic             div_zero;
  logic             sgn_ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;

  // One restoring step plus the sign-corrected final values.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic             last_iter;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    op_signed   = ~DivOp[0];
    op_rem      = DivOp[1];
    rs1_neg     = op_signed & RUrs1[WIDTH-1];
    rs2_neg     = op_signed & RUrs2[WIDTH-1];
    rs1_mag     = rs1_neg ? (~RUrs1 + 1'b1) : RUrs1;
    rs2_mag     = rs2_neg ? (~RUrs2 + 1'b1) : RUrs2;
    div_zero    = (RUrs2 == '0);
    sgn_ovf     = op_signed
                & (RUrs1 == {1'b1, {(WIDTH-1){1'b0}}})
                & (RUrs2 == '1);
    special     = div_zero | sgn_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op_rem ? RUrs1 : '1;
    end else if (sgn_ovf) begin
      // Most negative / -1: quotient wraps to the dividend, remainder is zero.
      special_res = op_rem ? '0 : RUrs1;
    end
  end

  // The partial remainder is always below the divisor, so after the shift it
  // fits in WIDTH+1 bits and bit WIDTH of the difference is a clean borrow.
  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvsr_q};
    take      = ~diff[WIDTH];
    rem_d     = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], take};
    rem_fix   = r_neg_q ? (~rem_d + 1'b1) : rem_d;
    quo_fix   = q_neg_q ? (~quo_d + 1'b1) : quo_d;
    last_iter = (cnt_q == LAST_CNT);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are cleared too, so an aborted operation
      // leaves no stale operands or signs behind.
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (special) begin
              res_q  <= special_res;
              done_q <= 1'b1;
            end else begin
              state_q  <= S_CALC;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              rem_q    <= '0;
              quo_q    <= rs1_mag;
              dvsr_q   <= rs2_mag;
              is_rem_q <= op_rem;
              q_neg_q  <= rs1_neg ^ rs2_neg;
              r_neg_q  <= rs1_neg;
            end
          end
        end

        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            res_q   <= is_rem_q ? rem_fix : quo_fix;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign DivRes = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: an arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_div_unit;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] rs1   = '0;
  logic [W-1:0] rs2   = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] res;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .DivOp  (op),
    .RUrs1  (rs1),
    .RUrs2  (rs2),
    .busy   (busy),
    .done   (done),
    .DivRes (res)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference result from plain 64-bit arithmetic (SV '/' truncates toward zero).
  function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (b == '0) return o[1] ? a : '1;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      return o[1] ? sr[W-1:0] : sq[W-1:0];
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return o[1] ? ur[W-1:0] : uq[W-1:0];
  endfunction

  function automatic logic is_special(input logic [1:0] o, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
    return (b == '0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Timeline model: an accepted normal op finishes 32 edges later.
  int           cyc      = 0;
  int           fin_edge = 0;
  logic         model_on = 1'b0;
  logic         pend     = 1'b0;
  logic [W-1:0] pend_res = '0;
  logic [W-1:0] exp_res  = '0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    model_on <= 1'b1;
    if (!rst_n) begin
      pend     <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_res  <= '0;
    end else begin
      exp_done <= 1'b0;
      if (pend) begin
        if (cyc == fin_edge) begin
          pend     <= 1'b0;
          exp_busy <= 1'b0;
          exp_done <= 1'b1;
          exp_res  <= pend_res;
        end
      end else if (start) begin
        if (is_special(op, rs1, rs2)) begin
          exp_done <= 1'b1;
          exp_res  <= ref_div(op, rs1, rs2);
        end else begin
          pend     <= 1'b1;
          exp_busy <= 1'b1;
          fin_edge <= cyc + W;
          pend_res <= ref_div(op, rs1, rs2);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("cyc_busy", W'(busy), W'(exp_busy));
      check("cyc_done", W'(done), W'(exp_done));
      check("cyc_DivRes", res, exp_res);
    end
  end

  // Called at a negedge; returns at the negedge right after the start edge,
  // with the operand inputs scrambled to prove they were latched.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  // Latency = edges from the start edge to the edge that raised done.
  task automatic wait_done(input string name, input int lat0, input int exp_lat,
                           input logic [W-1:0] exp_v);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, W'(lat), W'(exp_lat));
    check({name, "_result"}, res, exp_v);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_v);
    issue(o, a, b);
    wait_done(name, 0, exp_lat, exp_v);
    @(negedge clk);
  endtask

  initial begin
    int seen;

    // Reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_DivRes", res, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Signed, unsigned and edge-magnitude vectors (op: 00 DIV 01 DIVU 10 REM 11 REMU).
    run_op("div_m20_3",    2'b00, 32'hFFFF_FFEC, 32'd3,         32, 32'hFFFF_FFFA);
    run_op("rem_m20_3",    2'b10, 32'hFFFF_FFEC, 32'd3,         32, 32'hFFFF_FFFE);
    run_op("divu_max_2",   2'b01, 32'hFFFF_FFFF, 32'd2,         32, 32'h7FFF_FFFF);
    run_op("remu_100_7",   2'b11, 32'd100,       32'd7,         32, 32'd2);
    run_op("div_7_m2",     2'b00, 32'd7,         32'hFFFF_FFFE, 32, 32'hFFFF_FFFD);
    run_op("rem_7_m2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32, 32'd1);
    run_op("div_m1_m1",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'd1);
    run_op("div_min_2",    2'b00, 32'h8000_0000, 32'd2,         32, 32'hC000_0000);
    run_op("rem_min_3",    2'b10, 32'h8000_0000, 32'd3,         32, 32'hFFFF_FFFE);
    run_op("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0);

    // Divide by zero and signed overflow complete without iterating.
    run_op("div_5_0",      2'b00, 32'd5,         32'd0,         0,  32'hFFFF_FFFF);
    run_op("rem_5_0",      2'b10, 32'd5,         32'd0,         0,  32'd5);
    run_op("divu_5_0",     2'b01, 32'd5,         32'd0,         0,  32'hFFFF_FFFF);
    run_op("remu_1234_0",  2'b11, 32'h1234,      32'd0,         0,  32'h1234);
    run_op("div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0,  32'h8000_0000);
    run_op("rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0,  32'd0);

    // start held high with new operands during CALC is ignored.
    op    = 2'b01;
    rs1   = 32'd100;
    rs2   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    op  = 2'b00;
    rs1 = 32'd50;
    rs2 = 32'd5;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done("hold_start", 5, 32, 32'd14);

    // A start in the done cycle is accepted back-to-back.
    issue(2'b10, 32'hFFFF_FFEC, 32'd3);
    wait_done("back_to_back", 0, 32, 32'hFFFF_FFFE);
    @(negedge clk);

    // Reset in the middle of CALC aborts with no done pulse.
    issue(2'b00, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_DivRes", res, '0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", W'(seen), '0);

    // Unit still works after the abort.
    run_op("after_rst",    2'b11, 32'd100,       32'd7,         32, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit that executes DIV, DIVU, REM and REMU.
- Sits directly downstream of the register unit: consumes the RUrs1/RUrs2 read values and produces a result for the write-back mux, which writes it to rd.
- Radix-2 restoring algorithm, one quotient bit per clock. A start/busy/done handshake lets the control unit stall the PC while the operation runs.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- DivOp  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- RUrs1  input  WIDTH  dividend, from register unit port rs1.
- RUrs2  input  WIDTH  divisor, from register unit port rs2.
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse: DivRes is valid and newly updated.
- DivRes  output  WIDTH  selected quotient or remainder; holds until the next completion.

Behaviour:
- Reset (rst_n low at a clock edge, including mid-operation): state IDLE, busy=0, done=0, DivRes=0, all internal registers 0. Any in-flight operation is discarded with no done pulse.
- States: IDLE, CALC.
- IDLE, start=0: outputs hold; done=0.
- IDLE, start=1 at edge E0: operands and DivOp are latched. Later changes on RUrs1, RUrs2 or DivOp have no effect.
- Signed ops (DIV, REM): operands are converted to magnitudes. Record quotient sign = sign(rs1) XOR sign(rs2), and remainder sign = sign(rs1).
- Special cases, resolved at E0 with no iteration (state stays IDLE, busy stays 0, DivRes loaded and done=1 for the cycle after E0):
  - Divisor 0: DIV/DIVU result is all-ones; REM/REMU result is the dividend unchanged.
  - Signed overflow (DIV/REM only, rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Otherwise at E0: state goes to CALC, busy=1, iteration counter=0.
- CALC, each edge:
  - Shift {rem, quo} left by one bit.
  - Trial subtract the divisor from rem using a WIDTH+1-bit subtraction.
  - If non-negative, rem takes the difference and quo LSB=1; else quo LSB=0.
  - Counter increments.
- Final iteration (edge E_WIDTH, i.e. 32 edges after E0):
  - Sign correction applied combinationally to the final values.
  - DivRes loads quo (DIV/DIVU) or rem (REM/REMU).
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Latency: normal ops have done high in the cycle after the WIDTH-th CALC edge; special cases have done high in the cycle after E0.
- done is never high for two consecutive cycles unless a new start is accepted in the done cycle.
- start while busy=1 is ignored and not queued.
- start asserted in the same cycle done=1 (state is IDLE) is accepted; back-to-back operations are allowed.
- Width rules: remainder sign follows the dividend; quotient truncates toward zero. Magnitude of 0x80000000 is handled as unsigned 2^31, with no overflow in the WIDTH+1-bit datapath.
- done and DivRes are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> busy=0, done=0, DivRes=0. Assert rst_n=0 mid-CALC -> next cycle busy=0, no done pulse.
- DIV: RUrs1=0xFFFFFFEC (-20), RUrs2=3, start pulse -> busy for 32 cycles, then done=1, DivRes=0xFFFFFFFA (-6). Same operands with REM -> DivRes=0xFFFFFFFE (-2).
- Unsigned: DIVU 0xFFFFFFFF/2 -> DivRes=0x7FFFFFFF. REMU 100/7 -> DivRes=2. Both complete 32 cycles after start.
- Divide by zero: DIV 5/0 -> done the cycle after start, DivRes=0xFFFFFFFF, busy never 1. REM 5/0 -> DivRes=5.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> DivRes=0x80000000, done after 1 cycle. REM with same operands -> DivRes=0.
- Handshake: start held high and operands changed during CALC -> result reflects the original operands and the extra start is ignored. New start in the done cycle -> second operation accepted and completes 32 cycles later.
